// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the shared register-file write port: round-robin grant among
// ALU/LSU/MDU, a one-entry registered write stage, and bypass of that stage onto both read ports.
module rf_wb_arbiter #(
   parameter int DWIDTH = 32,
   parameter int NREQ   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [4:0]        alu_rd,
   input  logic [DWIDTH-1:0] alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [4:0]        lsu_rd,
   input  logic [DWIDTH-1:0] lsu_data,
   output logic              lsu_ready,
   input  logic              mdu_valid,
   input  logic [4:0]        mdu_rd,
   input  logic [DWIDTH-1:0] mdu_data,
   output logic              mdu_ready,
   output logic [4:0]        rd,
   output logic [DWIDTH-1:0] writedata,
   output logic              RegWen,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [DWIDTH-1:0] porta_in,
   input  logic [DWIDTH-1:0] portb_in,
   output logic [DWIDTH-1:0] fwd_a,
   output logic [DWIDTH-1:0] fwd_b
);

   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   gnt;
   logic [4:0]        req_rd   [NREQ];
   logic [DWIDTH-1:0] req_data [NREQ];
   logic [1:0]        ptr;
   logic [1:0]        gnt_idx;
   logic [2:0]        scan_idx;
   logic              xfer;

   logic              wen_p1;
   logic [4:0]        rd_p1;
   logic [DWIDTH-1:0] data_p1;

   function automatic logic [1:0] rr_next(input logic [1:0] k);
      return (k == 2'(NREQ - 1)) ? 2'd0 : k + 2'd1;
   endfunction

   function automatic logic [DWIDTH-1:0] bypass(
      input logic              wen,
      input logic [4:0]        wr_idx,
      input logic [DWIDTH-1:0] wr_data,
      input logic [4:0]        rs,
      input logic [DWIDTH-1:0] raw
   );
      return (wen && (wr_idx == rs) && (rs != 5'd0)) ? wr_data : raw;
   endfunction

   assign req         = {mdu_valid, lsu_valid, alu_valid};
   assign req_rd[0]   = alu_rd;
   assign req_rd[1]   = lsu_rd;
   assign req_rd[2]   = mdu_rd;
   assign req_data[0] = alu_data;
   assign req_data[1] = lsu_data;
   assign req_data[2] = mdu_data;

   // Scan requesters starting at ptr, wrapping modulo NREQ; first valid one wins.
   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      xfer     = 1'b0;
      scan_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         scan_idx = {1'b0, ptr} + 3'(i);
         if (scan_idx >= 3'(NREQ))
            scan_idx = scan_idx - 3'(NREQ);
         if (!xfer && req[scan_idx[1:0]]) begin
            gnt[scan_idx[1:0]] = 1'b1;
            gnt_idx            = scan_idx[1:0];
            xfer               = 1'b1;
         end
      end
   end

   assign alu_ready = gnt[0];
   assign lsu_ready = gnt[1];
   assign mdu_ready = gnt[2];

   // Stage p1: registered write toward the regfile; x0 writes are accepted but never enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= '0;
         wen_p1  <= 1'b0;
         rd_p1   <= '0;
         data_p1 <= '0;
      end else begin
         wen_p1 <= xfer && (req_rd[gnt_idx] != 5'd0);
         if (xfer) begin
            ptr     <= rr_next(gnt_idx);
            rd_p1   <= req_rd[gnt_idx];
            data_p1 <= req_data[gnt_idx];
         end
      end
   end

   assign RegWen    = wen_p1;
   assign rd        = rd_p1;
   assign writedata = data_p1;

   assign fwd_a = bypass(wen_p1, rd_p1, data_p1, rs1, porta_in);
   assign fwd_b = bypass(wen_p1, rd_p1, data_p1, rs2, portb_in);

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and bypass unit for the 32-entry register file. Three producers share the file's single write port: ALU, load/store unit and multiply/divide unit. Each cycle the block grants at most one producer in round-robin order and registers the winning write into a one-entry output stage that drives the file's `rd`/`writedata`/`RegWen`. It also forwards that pending write to both read ports, so decode never reads a stale value during the write's flight cycle.

## Interface

Parameters:
- `DWIDTH`, 32, data width of every write-back and read value
- `NREQ`, 3, number of requesters; fixed at 3 (index 0 = ALU, 1 = LSU, 2 = MDU)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_valid` / `lsu_valid` / `mdu_valid`  in  1 each  producer has a write-back pending
- `alu_rd` / `lsu_rd` / `mdu_rd`  in  5 each  destination register index
- `alu_data` / `lsu_data` / `mdu_data`  in  DWIDTH each  write-back value
- `alu_ready` / `lsu_ready` / `mdu_ready`  out  1 each  grant; a transfer occurs on a clock edge where valid & ready
- `rd`  out  5  to regfile write index
- `writedata`  out  DWIDTH  to regfile write data
- `RegWen`  out  1  to regfile write enable
- `rs1`, `rs2`  in  5 each  read indices (same values driven to the regfile)
- `porta_in`, `portb_in`  in  DWIDTH each  raw regfile read data
- `fwd_a`, `fwd_b`  out  DWIDTH each  bypassed read data for the decode stage

## Operation

- Arbitration is combinational. The round-robin pointer `ptr` (2 bits, values 0..2) marks the highest-priority requester. Priority order is ptr, ptr+1, ptr+2 mod 3.
- At most one `*_ready` is high per cycle. It is the first requester in priority order with `*_valid`=1. Ready is never high for a requester whose valid is low.
- Ready does not depend on downstream state, because the regfile accepts a write every cycle.
- On a transfer by requester k, `ptr` becomes (k+1) mod 3. With no transfer, `ptr` holds.
- Output stage, on each edge:
  - `RegWen` <= transfer & (granted rd != 0)
  - `rd` and `writedata` <= granted values on a transfer; otherwise they hold.
- A write to x0 is accepted (ready high, pointer rotates) but produces `RegWen`=0.
- Bypass is combinational:
  - `fwd_a` = `writedata` if `RegWen` & (`rd`==`rs1`) & (`rs1`!=0), else `porta_in`
  - `fwd_b` follows the same rule with `rs2`/`portb_in`
- Producers must hold valid, rd and data stable until ready. Data changing while valid is high and ready is low is a protocol violation and is not checked.

## Timing

- Reset (`rst_n` low, asynchronous): `RegWen`=0, `rd`=0, `writedata`=0, `ptr`=0. Any in-flight write is discarded and never reaches the regfile.
- Ready outputs are combinational from valids and `ptr`, so they may be high during reset if valids are high. Transfers during reset are ignored: no state update occurs.
- Write latency: the transfer happens at edge N, and `RegWen`/`rd`/`writedata` are valid from N to N+1. The regfile stores the value at edge N+1 and `porta_in` reflects it after N+1. Bypass covers the N to N+1 window.
- Back-to-back transfers every cycle are supported. Throughput is one write per cycle aggregate.
- Fairness: when all three are continuously valid, grants cycle 0,1,2,0,… Any continuously valid requester is granted within 3 cycles.
- Simultaneous events:
  - Two producers targeting the same rd in consecutive cycles commit in grant order.
  - A read of a register written in the current output stage sees the new value through the bypass.

## Test plan

- Reset then idle: all valids low. Expect `RegWen`=0, `rd`=0, `writedata`=0, all readies 0, and `fwd_a`=`porta_in` for all cycles.
- Single ALU write: `alu_valid`=1, `alu_rd`=5, `alu_data`=0xDEADBEEF for one cycle. Expect `alu_ready`=1 that cycle. Next cycle expect `RegWen`=1, `rd`=5, `writedata`=0xDEADBEEF. With `rs1`=5 and `porta_in`=0, expect `fwd_a`=0xDEADBEEF. One cycle later expect `RegWen`=0.
- All three valid continuously for 6 cycles, with rd = 1, 2, 3 respectively. Expect grant sequence ALU, LSU, MDU, ALU, LSU, MDU, and `rd` at the output 1, 2, 3, 1, 2, 3, each one cycle after its grant.
- x0 write: `lsu_valid`=1, `lsu_rd`=0, `lsu_data`=0x1234. Expect `lsu_ready`=1 and `ptr` advancing to 2, but `RegWen`=0. With `rs2`=0 and `portb_in`=0, expect `fwd_b`=0.
- Pointer hold: a grant to MDU (ptr becomes 0), then 2 idle cycles, then LSU and ALU raised together. Expect ALU granted first, then LSU.
- Reset mid-flight: ALU transfer with rd=7 at edge N, then `rst_n` pulsed low between N and N+1. Expect `RegWen` to drop to 0 immediately, regfile x7 unchanged, and `ptr`=0 after reset.
